contador_sequencer: RTL and testbench

Controller that shares the 8-bit up/down counter (`acrescer`/`decrecer` step interface) between two requesters. Each requester submits a target value over a valid/ready handshake. A round-robin arbiter grants one job at a time. The sequencer then steps the counter by one per cycle until its value equals the target, and pulses `done` with the served client's id. It sits beside the counter: counter output feeds back into `cnt_value`, sequencer drives the counter's step inputs.

---
 rtl/contador_pkg.sv | 19 +
 rtl/contador_rr_arbiter.sv | 61 ++++++
 rtl/contador_sequencer.sv | 114 +++++++++++
 tb/tb_contador_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// contador_pkg
// Shared types and constants for the counter sequencer slice.
//   DEF_WIDTH   : default counter/target width
//   CLIENT_0/1  : requester ids as carried on grant_id
//   seq_state_t : sequencer FSM state encoding
package contador_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic CLIENT_0 = 1'b0;
  localparam logic CLIENT_1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/contador_rr_arbiter.sv
// contador_rr_arbiter
// Two-way round-robin arbiter. The client not granted last has priority;
// after reset client 0 is favoured. A lone requester always wins.
// Ports:
//   clk, rst : clock, synchronous active-high reset (resets the pointer)
//   req      : request vector, bit i = client i
//   advance  : grant accepted this cycle; only then does the pointer move
//   gnt      : one-hot grant
//   gnt_id   : index of the granted client
module contador_rr_arbiter
  import contador_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Client that wins when both request.
  logic r_ptr;

  always_comb begin
    gnt    = 2'b00;
    gnt_id = CLIENT_0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = CLIENT_0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = CLIENT_1;
      end
      2'b11: begin
        if (r_ptr == CLIENT_1) begin
          gnt    = 2'b10;
          gnt_id = CLIENT_1;
        end else begin
          gnt    = 2'b01;
          gnt_id = CLIENT_0;
        end
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = CLIENT_0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= CLIENT_0;
    end else if (advance && (req != 2'b00)) begin
      // Hand priority to the client that just lost (or did not ask).
      r_ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/contador_sequencer.sv
// contador_sequencer
// Shares an up/down step counter between two requesters. A granted job
// steps the counter one per cycle toward its target, then pulses done.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-client handshake (ready is a combinational grant)
//   req_target_0/1      : per-client target value
//   abort               : end the current job early (honoured in RUN only)
//   cnt_value           : live counter value fed back from the counter
//   acrescer/decrecer   : increment / decrement step to the counter
//   busy                : FSM not idle
//   grant_id            : client of the current or most recent job
//   done, done_abort    : completion pulse and its abort qualifier
module contador_sequencer
  import contador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_target_0,
  input  logic [WIDTH-1:0] req_target_1,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             acrescer,
  output logic             decrecer,
  output logic             busy,
  output logic             grant_id,
  output logic             done,
  output logic             done_abort
);

  seq_state_t       r_state;
  logic [WIDTH-1:0] r_target;
  logic             r_grant_id;
  logic             r_done_abort;

  logic [1:0]       w_gnt;
  logic             w_gnt_id;
  logic             w_idle_grant;
  logic             w_run;
  logic             w_lt;
  logic             w_gt;

  // A grant only happens from IDLE; rst masks it so ready reads 0 in reset.
  assign w_idle_grant = (r_state == IDLE) && (req_valid != 2'b00) && !rst;

  contador_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (w_idle_grant),
    .gnt     (w_gnt),
    .gnt_id  (w_gnt_id)
  );

  assign w_run = (r_state == RUN);
  assign w_lt  = (cnt_value < r_target);
  assign w_gt  = (cnt_value > r_target);

  assign req_ready  = w_idle_grant ? w_gnt : 2'b00;
  // Steps follow the live counter value, so external counter changes are tracked.
  assign acrescer   = w_run && !abort && w_lt;
  assign decrecer   = w_run && !abort && w_gt;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign grant_id   = r_grant_id;
  assign done_abort = r_done_abort;

  // Target is pure data: loaded on grant, never reset.
  always_ff @(posedge clk) begin
    if (w_idle_grant) begin
      r_target <= (w_gnt_id == CLIENT_1) ? req_target_1 : req_target_0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= CLIENT_0;
      r_done_abort <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_idle_grant) begin
            r_grant_id <= w_gnt_id;
            r_state    <= RUN;
          end
        end
        RUN: begin
          // Abort wins over reaching the target in the same cycle.
          if (abort) begin
            r_done_abort <= 1'b1;
            r_state      <= DONE;
          end else if (cnt_value == r_target) begin
            r_done_abort <= 1'b0;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_done_abort <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_done_abort <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_sequencer.sv
// tb_contador_sequencer
// Directed bench for contador_sequencer with a behavioural step counter
// closing the loop on cnt_value.
module tb_contador_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_target_0;
  logic [W-1:0] req_target_1;
  logic         abort;
  logic [W-1:0] cnt_value;
  logic         acrescer;
  logic         decrecer;
  logic         busy;
  logic         grant_id;
  logic         done;
  logic         done_abort;

  // Counter model: loadable, one step per cycle, not touched by rst.
  logic         ld;
  logic [W-1:0] ld_val;
  logic [W-1:0] cnt;

  int n_cmp;
  int n_err;

  int exp_seq [4];
  int ng;
  int bad_both;
  int bad_busy;
  int spur_done;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ld)            cnt <= ld_val;
    else if (acrescer) cnt <= cnt + 8'd1;
    else if (decrecer) cnt <= cnt - 8'd1;
  end

  assign cnt_value = cnt;

  contador_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_target_0 (req_target_0),
    .req_target_1 (req_target_1),
    .abort        (abort),
    .cnt_value    (cnt_value),
    .acrescer     (acrescer),
    .decrecer     (decrecer),
    .busy         (busy),
    .grant_id     (grant_id),
    .done         (done),
    .done_abort   (done_abort)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input logic [W-1:0] v);
    ld     = 1'b1;
    ld_val = v;
    cyc();
    ld     = 1'b0;
  endtask

  // Issue one job from IDLE and measure it cycle by cycle.
  task automatic run_job(input string tag, input int cl, input logic [W-1:0] tgt,
                         input int abort_after, input int e_up, input int e_dn,
                         input int e_lat, input int e_cnt, input int e_abt);
    int up = 0;
    int dn = 0;
    int lat = -1;
    int both = 0;
    int nbusy = 0;
    int gid = -1;
    int dab = -1;
    bit aborted = 1'b0;
    if (cl == 0) req_target_0 = tgt;
    else         req_target_1 = tgt;
    req_valid = (cl == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    chk({tag, "_ready"}, int'(req_ready), (cl == 0) ? 1 : 2);
    cyc();
    req_valid = 2'b00;
    for (int c = 1; c <= 300; c++) begin
      if (abort_after >= 0 && !aborted && (up + dn) == abort_after) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clk);
      if (acrescer && decrecer) both++;
      if (!busy) nbusy++;
      up += int'(acrescer);
      dn += int'(decrecer);
      if (done) begin
        lat = c;
        gid = int'(grant_id);
        dab = int'(done_abort);
      end
      cyc();
      abort = 1'b0;
      if (lat >= 0) break;
    end
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_up_steps"}, up, e_up);
    chk({tag, "_dn_steps"}, dn, e_dn);
    chk({tag, "_grant_id"}, gid, cl);
    chk({tag, "_done_abort"}, dab, e_abt);
    chk({tag, "_both_steps"}, both, 0);
    chk({tag, "_busy_in_run"}, nbusy, 0);
    chk({tag, "_cnt"}, int'(cnt), e_cnt);
    @(negedge clk);
    chk({tag, "_idle_after"}, int'(busy), 0);
    chk({tag, "_done_once"}, int'(done), 0);
    cyc();
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    req_valid    = 2'b00;
    abort        = 1'b0;
    req_target_0 = '0;
    req_target_1 = '0;
    ld           = 1'b1;
    ld_val       = 8'd106;
    exp_seq      = '{0, 1, 0, 1};
    cyc();
    cyc();
    ld = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_abort", int'(done_abort), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_acrescer", int'(acrescer), 0);
    chk("rst_decrecer", int'(decrecer), 0);
    cyc();
    rst = 1'b0;

    // Increment, decrement, zero distance
    run_job("inc", 0, 8'd110, -1, 4, 0, 6, 110, 0);
    load_cnt(8'd106);
    run_job("dec", 1, 8'd100, -1, 0, 6, 8, 100, 0);
    run_job("zero", 1, 8'd100, -1, 0, 0, 2, 100, 0);

    // Arbitration with both clients held valid
    load_cnt(8'd106);
    req_target_0 = 8'd108;
    req_target_1 = 8'd104;
    req_valid    = 2'b11;
    ng       = 0;
    bad_both = 0;
    bad_busy = 0;
    for (int c = 0; c < 400 && ng < 4; c++) begin
      @(negedge clk);
      if (req_ready == 2'b11) bad_both++;
      if (req_ready != 2'b00 && busy) bad_busy++;
      if (req_ready != 2'b00) begin
        chk($sformatf("arb_grant%0d", ng), req_ready[1] ? 1 : 0, exp_seq[ng]);
        ng++;
      end
      cyc();
    end
    req_valid = 2'b00;
    chk("arb_ngrants", ng, 4);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      cyc();
    end
    chk("arb_drained", int'(busy), 0);
    chk("arb_ready_both", bad_both, 0);
    chk("arb_grant_busy", bad_busy, 0);
    chk("arb_cnt", int'(cnt), 104);
    cyc();

    // Abort after 10 steps, then a normal job
    load_cnt(8'd106);
    run_job("abort", 0, 8'd200, 10, 10, 0, 12, 116, 1);
    run_job("post_abort", 1, 8'd118, -1, 2, 0, 4, 118, 0);

    // Reset mid-RUN after a client-0 grant moved priority to client 1
    load_cnt(8'd106);
    req_target_0 = 8'd130;
    req_valid    = 2'b01;
    @(negedge clk);
    chk("mid_ready", int'(req_ready), 1);
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    @(negedge clk);
    chk("mid_stepping", int'(acrescer), 1);
    cyc();
    rst       = 1'b1;
    req_valid = 2'b11;
    spur_done = 0;
    cyc();
    @(negedge clk);
    if (done) spur_done++;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_acrescer", int'(acrescer), 0);
    chk("mid_rst_decrecer", int'(decrecer), 0);
    chk("mid_rst_grant_id", int'(grant_id), 0);
    chk("mid_rst_done_abort", int'(done_abort), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    if (done) spur_done++;
    chk("mid_rst_no_done", spur_done, 0);
    chk("mid_rst_prio0", int'(req_ready), 1);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_rst_regrant_id", int'(grant_id), 0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) break;
      cyc();
    end
    chk("mid_rst_final_idle", int'(busy), 0);
    chk("mid_rst_final_cnt", int'(cnt), 130);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
